// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and captured-request record for the MEM-stage
// data-memory access unit.
package mem_access_pkg;

  localparam logic [1:0] DM_BYTE = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Everything the bus side needs, latched once when the access is accepted
  typedef struct packed {
    logic        we;
    logic [1:0]  dm_type;
    logic        ext;
    logic [1:0]  a;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic [3:0] gen_be(input logic [1:0] dm_type, input logic [1:0] a);
    logic [3:0] be;
    case (dm_type)
      DM_BYTE: be = 4'b0001 << a;
      DM_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] gen_wdata(input logic [1:0] dm_type, input logic [31:0] rt);
    logic [31:0] wd;
    case (dm_type)
      DM_BYTE: wd = {4{rt[7:0]}};
      DM_HALF: wd = {2{rt[15:0]}};
      default: wd = rt;
    endcase
    return wd;
  endfunction

  // Type 11 behaves as a word, so anything with bit 1 set needs word alignment
  function automatic logic misaligned(input logic [1:0] dm_type, input logic [1:0] a);
    return dm_type[1] ? (a != 2'b00) : ((dm_type == DM_HALF) && a[0]);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it; words pass through untouched.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  dm_type,
  input  logic        ext,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = rdata >> {a, 3'b000};

  always_comb begin
    data = rdata;
    case (dm_type)
      DM_BYTE: data = ext ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      DM_HALF: data = ext ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus handshake with wait states and
// timeout, pipeline stall generation, store data replication and load alignment.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_dmen,
  input  logic        mem_memwr,
  input  logic [1:0]  mem_dm_type,
  input  logic        mem_dm_extsigned,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rt,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic        mem_bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t          state, state_nx;
  acc_t            acc, acc_in;
  logic [TO_W-1:0] cnt;
  logic            bad_align;
  logic            start;
  logic            to_hit;
  logic [31:0]     aligned;

  assign bad_align = misaligned(mem_dm_type, mem_result[1:0]);
  assign start     = (state == IDLE) && mem_dmen && !bad_align;
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // Faults are only meaningful while the access is being presented in IDLE
  assign mem_adel = (state == IDLE) && mem_dmen && bad_align && !mem_memwr;
  assign mem_ades = (state == IDLE) && mem_dmen && bad_align && mem_memwr;

  always_comb begin
    acc_in.we      = mem_memwr;
    acc_in.dm_type = mem_dm_type;
    acc_in.ext     = mem_dm_extsigned;
    acc_in.a       = mem_result[1:0];
    acc_in.addr    = {mem_result[31:2], 2'b00};
    acc_in.be      = gen_be(mem_dm_type, mem_result[1:0]);
    acc_in.wdata   = gen_wdata(mem_dm_type, mem_rt);
  end

  mem_load_align u_align (
    .rdata   (dbus_rdata),
    .a       (acc.a),
    .dm_type (acc.dm_type),
    .ext     (acc.ext),
    .data    (aligned)
  );

  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = REQ;
          mem_stall = 1'b1;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dbus_ack || to_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign dbus_req   = (state == REQ);
  assign dbus_we    = (state == REQ) && acc.we;
  assign dbus_be    = (state == REQ) ? acc.be : 4'b0000;
  assign dbus_addr  = acc.addr;
  assign dbus_wdata = acc.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      mem_load_data  <= '0;
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
    end else begin
      state          <= state_nx;
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) acc <= acc_in;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // Ack takes priority over a timeout landing in the same cycle
          if (dbus_ack) begin
            mem_load_data  <= acc.we ? 32'h0 : aligned;
            mem_load_valid <= !acc.we;
          end else if (to_hit) begin
            mem_load_data  <= 32'h0;
            mem_load_valid <= !acc.we;
            mem_bus_err    <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
